// File: rtl/flasher_ctl.sv
// I2C-controlled two-LED blinker: a 7-bit-addressed I2C slave writes a small
// register file that selects alternate/sync blinking and can freeze the phase.
module flasher_ctl #(
  parameter logic [6:0]  I2C_ADDR   = 7'h41,
  parameter int unsigned BLINK_HALF = 10_000_000,
  parameter logic [5:0]  ID_VALUE   = 6'h2A
) (
  input  logic CLK,
  input  logic RST,
  input  logic SCL,
  inout  wire  SDA,
  output logic LEDR,
  output logic LEDG
);

  localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [6:0]  shift, shift_nx;
  logic [1:0]  ack_ph, ack_ph_nx;
  logic        rw, rw_nx;
  logic        sda_oe, oe_nx;
  logic [5:0]  ptr, ptr_nx;
  logic [5:0]  scratch, scratch_nx;
  logic [5:0]  ctrl, ctrl_nx;

  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start, stop;
  logic [7:0]  rx_byte, tx_byte;
  logic [5:0]  rd_val;

  logic [CW-1:0] cnt;
  logic          phase;

  // Open-drain: only ever pull low or release.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte  = {shift, sda_s};

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    case (ptr)
      6'd0:    rd_val = ID_VALUE;
      6'd1:    rd_val = scratch;
      6'd2:    rd_val = ctrl;
      default: rd_val = '0;
    endcase
  end

  assign tx_byte = {2'b01, rd_val};

  // I2C slave state and register-file update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ack_ph  <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      ptr     <= '0;
      scratch <= '0;
      ctrl    <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
      ack_ph  <= ack_ph_nx;
      rw      <= rw_nx;
      sda_oe  <= oe_nx;
      ptr     <= ptr_nx;
      scratch <= scratch_nx;
      ctrl    <= ctrl_nx;
    end
  end

  // Next-state logic; ACK states step through ack_ph:
  // 0 = wait end of 8th clock, 1 = wait 9th rise, 2 = wait end of 9th clock.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    ack_ph_nx  = ack_ph;
    rw_nx      = rw;
    oe_nx      = sda_oe;
    ptr_nx     = ptr;
    scratch_nx = scratch;
    ctrl_nx    = ctrl;

    if (start) begin
      state_nx   = S_ADDR;
      bit_cnt_nx = '0;
      oe_nx      = 1'b0;
    end else if (stop) begin
      state_nx = S_IDLE;
      oe_nx    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: ;

        S_ADDR, S_WR_BYTE: begin
          if (scl_rise) begin
            shift_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_ph_nx = 2'd0;
              if (state == S_ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_nx = S_ADDR_ACK;
                  rw_nx    = rx_byte[0];
                end else begin
                  state_nx = S_IGNORE;
                end
              end else begin
                state_nx = S_WR_ACK;
                case (rx_byte[7:6])
                  2'b00: ptr_nx = rx_byte[5:0];
                  2'b01: begin
                    if (ptr == 6'd1) scratch_nx = rx_byte[5:0];
                    else if (ptr == 6'd2) ctrl_nx = rx_byte[5:0];
                  end
                  default: ;
                endcase
              end
            end
          end
        end

        S_ADDR_ACK, S_WR_ACK: begin
          case (ack_ph)
            2'd0: if (scl_fall) begin
              oe_nx     = 1'b1;
              ack_ph_nx = 2'd1;
            end
            2'd1: if (scl_rise) ack_ph_nx = 2'd2;
            default: if (scl_fall) begin
              bit_cnt_nx = '0;
              if (state == S_ADDR_ACK && rw) begin
                state_nx = S_RD_BYTE;
                oe_nx    = ~tx_byte[7];
              end else begin
                state_nx = S_WR_BYTE;
                oe_nx    = 1'b0;
              end
            end
          endcase
        end

        S_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx  = S_RD_ACK;
              ack_ph_nx = 2'd0;
            end
          end else if (scl_fall) begin
            oe_nx = ~tx_byte[3'd7 - bit_cnt];
          end
        end

        S_RD_ACK: begin
          case (ack_ph)
            2'd0: if (scl_fall) begin
              oe_nx     = 1'b0;
              ack_ph_nx = 2'd1;
            end
            2'd1: if (scl_rise) begin
              if (sda_s) state_nx = S_IGNORE;
              else       ack_ph_nx = 2'd2;
            end
            default: if (scl_fall) begin
              state_nx   = S_RD_BYTE;
              bit_cnt_nx = '0;
              oe_nx      = ~tx_byte[7];
            end
          endcase
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Free-running half-period counter; freeze stalls counter and phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!ctrl[1]) begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered LED drive: alternate (mode 0) or synchronous (mode 1).
  always_ff @(posedge CLK) begin
    if (RST) begin
      LEDR <= 1'b0;
      LEDG <= 1'b1;
    end else begin
      LEDR <= phase;
      LEDG <= ctrl[0] ? phase : ~phase;
    end
  end

endmodule

// File: tb/tb_flasher_ctl.sv
// Directed bench for flasher_ctl: bit-banged I2C host plus LED checks.
module tb_flasher_ctl;

  localparam int unsigned Q = 5;  // CLK cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_low;
  wire  sda_bus;
  logic ledr, ledg;

  int n_checks = 0;
  int n_errors = 0;
  int drive_cnt = 0;
  logic mon_en = 1'b0;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  flasher_ctl #(
    .I2C_ADDR  (7'h41),
    .BLINK_HALF(4),
    .ID_VALUE  (6'h2A)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .SCL (scl),
    .SDA (sda_bus),
    .LEDR(ledr),
    .LEDG(ledg)
  );

  always #5 clk = ~clk;

  // Counts cycles where the DUT pulls SDA low while monitoring is enabled.
  always @(negedge clk)
    if (mon_en && !sda_low && sda_bus == 1'b0) drive_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b0; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_low = ~b; wait_q();
    scl = 1'b1;   wait_q(); wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    b = sda_bus;    wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic wb_ack(input string tag, input logic [7:0] d);
    logic ack;
    write_byte(d, ack);
    check(tag, {31'd0, ack}, 32'd1);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic host_ack);
    logic [7:0] tmp;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      tmp[i] = b;
    end
    write_bit(~host_ack);
    d = tmp;
  endtask

  initial begin
    logic [7:0] d, d2;
    logic ack, b, prev;
    int toggles;

    rst = 1'b1; scl = 1'b1; sda_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ledr", {31'd0, ledr}, 32'd0);
    check("rst_ledg", {31'd0, ledg}, 32'd1);
    check("rst_sda", {31'd0, sda_bus}, 32'd1);
    rst = 1'b0;

    // Test 1: alternate blinking, period 4 CLK per half.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("alt_ledr", {31'd0, ledr}, ((k - 1) / 4) % 2);
      check("alt_ledg", {31'd0, ledg}, 1 - ((k - 1) / 4) % 2);
    end

    // Test 2: select sync mode.
    i2c_start();
    wb_ack("t2_addr", 8'h82);
    wb_ack("t2_ptr", 8'h02);
    wb_ack("t2_data", 8'h41);
    i2c_stop();
    toggles = 0;
    prev = ledr;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("sync_eq", {31'd0, ledr}, {31'd0, ledg});
      if (ledr != prev) toggles++;
      prev = ledr;
    end
    check("sync_toggles", toggles, 4);

    // Freeze: LEDs hold still, then restore sync + running.
    i2c_start();
    wb_ack("frz_addr", 8'h82);
    wb_ack("frz_data", 8'h43);
    i2c_stop();
    prev = ledr;
    toggles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ledr != prev) toggles++;
      prev = ledr;
    end
    check("frz_toggles", toggles, 0);
    i2c_start();
    wb_ack("unfrz_addr", 8'h82);
    wb_ack("unfrz_data", 8'h41);
    i2c_stop();

    // Test 3: wrong address is NACKed and never driven.
    drive_cnt = 0;
    mon_en = 1'b1;
    i2c_start();
    write_byte(8'h84, ack);
    check("t3_nack", {31'd0, ack}, 32'd0);
    write_byte(8'h40, ack);
    i2c_stop();
    mon_en = 1'b0;
    check("t3_no_drive", drive_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_still_sync", {31'd0, ledr}, {31'd0, ledg});
    end

    // Test 4: scratch write then read via repeated START.
    i2c_start();
    wb_ack("t4_addr", 8'h82);
    wb_ack("t4_ptr", 8'h01);
    wb_ack("t4_data", 8'h55);
    i2c_start();
    wb_ack("t4_raddr", 8'h83);
    read_byte(d, 1'b0);
    i2c_stop();
    check("t4_rd", {24'd0, d}, 32'h55);

    // Host ACK repeats the byte; NACK ends it.
    i2c_start();
    wb_ack("t4b_addr", 8'h82);
    wb_ack("t4b_ptr", 8'h02);
    i2c_start();
    wb_ack("t4b_raddr", 8'h83);
    read_byte(d, 1'b1);
    read_byte(d2, 1'b0);
    i2c_stop();
    check("t4b_rd1", {24'd0, d}, 32'h41);
    check("t4b_rd2", {24'd0, d2}, 32'h41);

    // Test 5: ID register is read-only.
    i2c_start();
    wb_ack("t5_addr", 8'h82);
    wb_ack("t5_ptr", 8'h00);
    i2c_start();
    wb_ack("t5_raddr", 8'h83);
    read_byte(d, 1'b0);
    i2c_stop();
    check("t5_id", {24'd0, d}, 32'h6A);
    i2c_start();
    wb_ack("t5w_addr", 8'h82);
    wb_ack("t5w_data", 8'h7F);
    i2c_start();
    wb_ack("t5w_raddr", 8'h83);
    read_byte(d, 1'b0);
    i2c_stop();
    check("t5_id_kept", {24'd0, d}, 32'h6A);

    // Test 6: reset during the 4th bit of a read (ID 0x6A, bit4 = 0).
    i2c_start();
    wb_ack("t6_raddr", 8'h83);
    for (int i = 0; i < 3; i++) read_bit(b);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    check("t6_bit4_driven", {31'd0, sda_bus}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_sda_released", {31'd0, sda_bus}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ledr", {31'd0, ledr}, 32'd0);
    check("t6_ledg", {31'd0, ledg}, 32'd1);
    scl = 1'b0; wait_q();
    i2c_start();
    wb_ack("t6_addr", 8'h82);
    wb_ack("t6_ptr", 8'h01);
    i2c_start();
    wb_ack("t6_raddr2", 8'h83);
    read_byte(d, 1'b0);
    i2c_stop();
    check("t6_scratch_zero", {24'd0, d}, 32'h40);
    i2c_start();
    wb_ack("t6c_addr", 8'h82);
    wb_ack("t6c_ptr", 8'h02);
    i2c_start();
    wb_ack("t6c_raddr", 8'h83);
    read_byte(d, 1'b0);
    i2c_stop();
    check("t6_ctrl_zero", {24'd0, d}, 32'h40);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_alt", {31'd0, ledr}, {31'd0, ~ledg});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
